// File: rtl/sound_pkg.sv
// Shared types and constants for the sound scheduler: FSM states,
// note-code widths and the fixed sound-effect note table.
package sound_pkg;

    localparam int NOTE_W   = 8;
    localparam int INDEX_W  = 6;
    localparam int FX_COUNT = 4;
    localparam int FX_STEPS = 4;

    localparam logic [NOTE_W-1:0] SILENCE = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // fx_note[id][step]; a 0 entry ends the effect early.
    localparam logic [INDEX_W-1:0] FX_NOTE [0:FX_COUNT-1][0:FX_STEPS-1] = '{
        '{6'd24, 6'd28, 6'd31, 6'd36},   // score
        '{6'd31, 6'd31, 6'd0,  6'd0 },   // paddle hit
        '{6'd19, 6'd0,  6'd0,  6'd0 },   // wall bounce
        '{6'd12, 6'd10, 6'd8,  6'd0 }    // miss
    };

    // Full 8-bit note code for an effect step; out-of-table lookups are silence.
    function automatic logic [NOTE_W-1:0] fx_code(input int unsigned id, input int unsigned step);
        logic [NOTE_W-1:0] code;
        code = SILENCE;
        if ((id < FX_COUNT) && (step < FX_STEPS)) begin
            code = {2'b00, FX_NOTE[id[1:0]][step[1:0]]};
        end
        return code;
    endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// Bundle between game logic / music path (master) and the scheduler (slave).
// Handshake: req bits are one-cycle event pulses with no back-pressure; the
// scheduler always accepts them (they are latched as pending). grant is a
// one-cycle pulse when an effect starts or restarts. fsm_state exposes the
// scheduler state for observation.
interface sound_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import sound_pkg::*;

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req;
    logic               music_en;
    logic [NOTE_W-1:0]  music_note;
    logic [NOTE_W-1:0]  note_out;
    logic               busy;
    logic [ID_W-1:0]    active_id;
    logic [NUM_REQ-1:0] grant;
    state_t             fsm_state;

    modport master (
        output req, music_en, music_note,
        input  note_out, busy, active_id, grant, fsm_state
    );

    modport slave (
        input  req, music_en, music_note,
        output note_out, busy, active_id, grant, fsm_state
    );

endinterface

// File: rtl/priority_pick.sv
// Lowest-index-set encoder over the pending vector (index 0 = highest priority).
module priority_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates the shared tone generator between background music and
// one-shot sound effects. Effects are latched, prioritized, played as short
// note sequences, followed by a silent gap.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int STEP_CYCLES = 4194304,
    parameter int GAP_CYCLES  = 262144
) (
    input  logic             clk,
    input  logic             rst_n,
    sound_scheduler_if.slave bus
);

    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MAX_CYC = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] clear;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;

    logic [NOTE_W-1:0]  note_q, note_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         step_q, step_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic preempt;
    logic start;
    logic cnt_zero;
    logic last_note;

    priority_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .pending (pending_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // A higher-priority pending effect restarts the generator during PLAY only.
    assign preempt   = (state_q == PLAY) && pick_valid && (pick_idx < id_q);
    assign start     = ((state_q == IDLE) && pick_valid) || preempt;
    assign cnt_zero  = (cnt_q == '0);
    // The effect ends after step 3 or when the next table entry is silence.
    assign last_note = (step_q == 2'd3) ||
                       (fx_code(32'(id_q), 32'(step_q) + 32'd1) == SILENCE);

    // Pending latch: a new request wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clear) | bus.req;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick_valid) state_d = PLAY;
            PLAY: begin
                if (preempt) begin
                    state_d = PLAY;
                end else if (cnt_zero && last_note) begin
                    state_d = GAP;
                end
            end
            GAP:  if (cnt_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: grants, note selection, step and counter.
    always_comb begin
        note_d  = note_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        id_d    = id_q;
        grant_d = '0;
        clear   = '0;
        if (start) begin
            clear[pick_idx]   = 1'b1;
            grant_d[pick_idx] = 1'b1;
            id_d              = pick_idx;
            step_d            = 2'd0;
            cnt_d             = STEP_LOAD;
            note_d            = fx_code(32'(pick_idx), 32'd0);
        end else begin
            case (state_q)
                IDLE: note_d = bus.music_en ? bus.music_note : SILENCE;
                PLAY: begin
                    if (cnt_zero) begin
                        if (last_note) begin
                            note_d = SILENCE;
                            cnt_d  = GAP_LOAD;
                        end else begin
                            step_d = step_q + 2'd1;
                            cnt_d  = STEP_LOAD;
                            note_d = fx_code(32'(id_q), 32'(step_q) + 32'd1);
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    note_d = SILENCE;
                    if (!cnt_zero) cnt_d = cnt_q - 1'b1;
                end
                default: note_d = SILENCE;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q  <= SILENCE;
            cnt_q   <= '0;
            step_q  <= 2'd0;
            id_q    <= '0;
            grant_q <= '0;
        end else begin
            note_q  <= note_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            id_q    <= id_d;
            grant_q <= grant_d;
        end
    end

    assign bus.note_out  = note_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.active_id = id_q;
    assign bus.grant     = grant_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with short note/gap timing.
module tb_sound_scheduler;
    import sound_pkg::*;

    localparam int STEP = 8;
    localparam int GAPC = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sound_scheduler_if #(.NUM_REQ(4)) bus();

    sound_scheduler #(
        .NUM_REQ     (4),
        .STEP_CYCLES (STEP),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] r);
        bus.req = r;
        tick();
        bus.req = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.req = 4'b0000;
        bus.music_en = 1'b0;
        bus.music_note = 8'd0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.note_out !== 8'd0) begin n_fail++; $display("FAIL reset_note: got %0d expected 0", bus.note_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
        n_checks++; if (bus.active_id !== 2'd0) begin n_fail++; $display("FAIL reset_active_id: got %0d expected 0", bus.active_id); end
        n_checks++; if (bus.fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", bus.fsm_state); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        bus.music_en = 1'b1;
        bus.music_note = 8'd17;
        n_checks++; if (bus.note_out !== 8'd0) begin n_fail++; $display("FAIL pass_latency: got %0d expected 0", bus.note_out); end
        tick();
        n_checks++; if (bus.note_out !== 8'd17) begin n_fail++; $display("FAIL pass_on: got %0d expected 17", bus.note_out); end
        bus.music_note = 8'd200;
        tick();
        n_checks++; if (bus.note_out !== 8'd200) begin n_fail++; $display("FAIL pass_wide: got %0d expected 200", bus.note_out); end
        bus.music_en = 1'b0;
        tick();
        n_checks++; if (bus.note_out !== 8'd0) begin n_fail++; $display("FAIL pass_off: got %0d expected 0", bus.note_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL pass_busy: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp_q[$];
        logic [7:0] seq[4];
        logic [7:0] exp;
        logic [3:0] exp_grant;
        int k;
        seq = '{8'd24, 8'd28, 8'd31, 8'd36};
        bus.music_en = 1'b1;
        bus.music_note = 8'd5;
        tick();
        pulse_req(4'b0001);
        tick();
        n_checks++; if (bus.active_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", bus.active_id); end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < STEP; c++) exp_q.push_back(seq[s]);
        end
        for (int g = 0; g < GAPC; g++) exp_q.push_back(8'd0);
        k = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            exp_grant = (k == 0) ? 4'b0001 : 4'b0000;
            n_checks++; if (bus.note_out !== exp) begin n_fail++; $display("FAIL single_note[%0d]: got %0d expected %0d", k, bus.note_out, exp); end
            n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d]: got %0b expected 1", k, bus.busy); end
            n_checks++; if (bus.grant !== exp_grant) begin n_fail++; $display("FAIL single_grant[%0d]: got %b expected %b", k, bus.grant, exp_grant); end
            k++;
            tick();
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.note_out !== 8'd0) begin n_fail++; $display("FAIL single_idle_note: got %0d expected 0", bus.note_out); end
        tick();
        n_checks++; if (bus.note_out !== 8'd5) begin n_fail++; $display("FAIL single_music_back: got %0d expected 5", bus.note_out); end
    endtask

    task automatic test_early_end();
        int busy_cycles;
        bus.music_en = 1'b0;
        pulse_req(4'b0100);
        tick();
        n_checks++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL early_grant: got %b expected 0100", bus.grant); end
        n_checks++; if (bus.active_id !== 2'd2) begin n_fail++; $display("FAIL early_id: got %0d expected 2", bus.active_id); end
        for (int c = 0; c < STEP; c++) begin
            n_checks++; if (bus.note_out !== 8'd19) begin n_fail++; $display("FAIL early_note[%0d]: got %0d expected 19", c, bus.note_out); end
            tick();
        end
        for (int g = 0; g < GAPC; g++) begin
            n_checks++; if (bus.note_out !== 8'd0) begin n_fail++; $display("FAIL early_gap[%0d]: got %0d expected 0", g, bus.note_out); end
            tick();
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL early_idle: got %0b expected 0", bus.busy); end
        // Re-run and count busy cycles independently.
        tick();
        pulse_req(4'b0100);
        tick();
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            tick();
        end
        n_checks++; if (busy_cycles !== STEP + GAPC) begin n_fail++; $display("FAIL early_busy_len: got %0d expected %0d", busy_cycles, STEP + GAPC); end
    endtask

    task automatic test_preempt();
        bus.music_en = 1'b0;
        pulse_req(4'b1000);
        tick();
        n_checks++; if (bus.grant !== 4'b1000) begin n_fail++; $display("FAIL pre_grant3: got %b expected 1000", bus.grant); end
        tick(); tick(); tick();
        n_checks++; if (bus.note_out !== 8'd12) begin n_fail++; $display("FAIL pre_note12: got %0d expected 12", bus.note_out); end
        pulse_req(4'b0010);
        n_checks++; if (bus.active_id !== 2'd3) begin n_fail++; $display("FAIL pre_still3: got %0d expected 3", bus.active_id); end
        tick();
        n_checks++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL pre_grant1: got %b expected 0010", bus.grant); end
        n_checks++; if (bus.active_id !== 2'd1) begin n_fail++; $display("FAIL pre_id1: got %0d expected 1", bus.active_id); end
        for (int c = 0; c < 2 * STEP; c++) begin
            n_checks++; if (bus.note_out !== 8'd31) begin n_fail++; $display("FAIL pre_note31[%0d]: got %0d expected 31", c, bus.note_out); end
            tick();
        end
        for (int g = 0; g < GAPC; g++) begin
            n_checks++; if (bus.busy !== 1'b1 || bus.note_out !== 8'd0) begin n_fail++; $display("FAIL pre_gap[%0d]: got busy %0b note %0d expected busy 1 note 0", g, bus.busy, bus.note_out); end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin n_fail++; $display("FAIL pre_no_resume[%0d]: got busy %0b grant %b expected busy 0 grant 0000", c, bus.busy, bus.grant); end
            tick();
        end
    endtask

    task automatic test_queue();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        bus.music_en = 1'b0;
        pulse_req(4'b1010);
        tick();
        n_checks++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL queue_grant1: got %b expected 0010", bus.grant); end
        for (int c = 0; c < 2 * STEP; c++) exp_q.push_back(8'd31);
        for (int g = 0; g < GAPC; g++) exp_q.push_back(8'd0);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++; if (bus.note_out !== exp) begin n_fail++; $display("FAIL queue_fx1_note: got %0d expected %0d", bus.note_out, exp); end
            tick();
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL queue_idle_busy: got %0b expected 0", bus.busy); end
        tick();
        n_checks++; if (bus.grant !== 4'b1000) begin n_fail++; $display("FAIL queue_grant3: got %b expected 1000", bus.grant); end
        n_checks++; if (bus.active_id !== 2'd3) begin n_fail++; $display("FAIL queue_id3: got %0d expected 3", bus.active_id); end
        for (int c = 0; c < STEP; c++) exp_q.push_back(8'd12);
        for (int c = 0; c < STEP; c++) exp_q.push_back(8'd10);
        for (int c = 0; c < STEP; c++) exp_q.push_back(8'd8);
        for (int g = 0; g < GAPC; g++) exp_q.push_back(8'd0);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++; if (bus.note_out !== exp || bus.busy !== 1'b1) begin n_fail++; $display("FAIL queue_fx3_note: got %0d busy %0b expected %0d busy 1", bus.note_out, bus.busy, exp); end
            tick();
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL queue_end_busy: got %0b expected 0", bus.busy); end
        tick();
    endtask

    task automatic test_retrigger();
        bus.music_en = 1'b0;
        pulse_req(4'b0100);
        tick();
        tick(); tick();
        pulse_req(4'b0100);
        n_checks++; if (bus.note_out !== 8'd19) begin n_fail++; $display("FAIL retrig_no_restart: got %0d expected 19", bus.note_out); end
        // Original effect: started 3 cycles ago, so 5 note cycles + gap remain.
        repeat (STEP - 3 + GAPC) tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL retrig_idle: got %0b expected 0", bus.busy); end
        tick();
        n_checks++; if (bus.grant !== 4'b0100 || bus.note_out !== 8'd19) begin n_fail++; $display("FAIL retrig_replay: got grant %b note %0d expected grant 0100 note 19", bus.grant, bus.note_out); end
        repeat (STEP + GAPC) tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL retrig_done: got %0b expected 0", bus.busy); end
        tick();
    endtask

    task automatic test_reset_mid_play();
        bus.music_en = 1'b0;
        pulse_req(4'b0001);
        tick();
        repeat (2 * STEP + 1) tick();
        n_checks++; if (bus.note_out !== 8'd31) begin n_fail++; $display("FAIL rmid_step2: got %0d expected 31", bus.note_out); end
        // Leave fx2 and fx3 pending, then reset asynchronously between edges.
        pulse_req(4'b1100);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.note_out !== 8'd0) begin n_fail++; $display("FAIL rmid_note: got %0d expected 0", bus.note_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rmid_grant: got %b expected 0000", bus.grant); end
        n_checks++; if (bus.active_id !== 2'd0) begin n_fail++; $display("FAIL rmid_id: got %0d expected 0", bus.active_id); end
        tick();
        rst_n = 1'b1;
        bus.music_en = 1'b1;
        bus.music_note = 8'd42;
        tick();
        for (int c = 0; c < 6; c++) begin
            n_checks++; if (bus.note_out !== 8'd42 || bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rmid_after[%0d]: got note %0d busy %0b grant %b expected note 42 busy 0 grant 0000", c, bus.note_out, bus.busy, bus.grant); end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_passthrough();
        test_single();
        test_early_end();
        test_preempt();
        test_queue();
        test_retrigger();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
